// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// hands each returned word (with its PC) to the decoder over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_ISSUE | request for pc goes out this cycle
// S_WAIT  | request outstanding, response will be captured
// S_FULL  | inst/inst_pc hold a live instruction awaiting the decoder
// S_DRAIN | request outstanding whose response must be discarded
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic            capture;
  logic            transfer;

  assign capture  = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign transfer = (state == S_FULL) && inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect outranks every other event; a redirect in WAIT must still
  // swallow the in-flight response, hence DRAIN unless it lands this cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_ISSUE: begin
        state_nxt = redirect_valid ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_rvalid ? S_ISSUE : S_DRAIN;
        end else if (imem_rvalid) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect_valid) begin
          state_nxt = S_ISSUE;
        end else if (inst_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_nxt = S_ISSUE;
        end
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst_n && !redirect_valid) begin
      imem_req = (state == S_ISSUE) || ((state == S_FULL) && inst_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= RESET_PC & WORD_MASK;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        pc         <= redirect_pc & WORD_MASK;
        inst_valid <= 1'b0;
      end else if (capture) begin
        pc         <= pc + XLEN'(4);
        inst_valid <= 1'b1;
        inst       <= imem_rdata;
        inst_pc    <= pc;
      end else if (transfer) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-by-cycle vector table plus a few
// multi-cycle sequences, with a latency-programmable memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_fail = 0;
  int mem_lat = 1;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory model: a request seen mid-cycle k returns data in cycle k+mem_lat.
  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = '0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_seen = 1'b0;
      cnt = 0;
    end else begin
      req_seen = imem_req;
      addr_seen = imem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (req_seen) begin
      cnt = mem_lat;
      pend_addr = addr_seen;
      req_seen = 1'b0;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_data(pend_addr);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic redir,
                              input logic [31:0] rpc, input logic ready,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance to next cycle.
  task automatic run_cycle(input string nm, input vec_t v);
    rst_n = v.rst;
    redirect_valid = v.redir;
    redirect_pc = v.rpc;
    inst_ready = v.ready;
    @(negedge clk);
    check({nm, ".imem_req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) check({nm, ".imem_addr"}, imem_addr, v.e_addr);
    check({nm, ".inst_valid"}, 32'(inst_valid), 32'(v.e_valid));
    check({nm, ".inst_pc"}, inst_pc, v.e_pc);
    check({nm, ".inst"}, inst, v.e_inst);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[28];

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 1, 32'h0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 1, 1, 32'h4, 1, 32'h0, mem_data(32'h0));
    vecs[5]  = mk(1, 0, 0, 1, 0, 0, 0, 32'h0, mem_data(32'h0));
    vecs[6]  = mk(1, 0, 0, 1, 1, 32'h8, 1, 32'h4, mem_data(32'h4));
    vecs[7]  = mk(1, 0, 0, 1, 0, 0, 0, 32'h4, mem_data(32'h4));
    for (int i = 8; i <= 12; i++)
      vecs[i] = mk(1, 0, 0, 0, 0, 0, 1, 32'h8, mem_data(32'h8));
    vecs[13] = mk(1, 0, 0, 1, 1, 32'hC, 1, 32'h8, mem_data(32'h8));
    vecs[14] = mk(1, 0, 0, 1, 0, 0, 0, 32'h8, mem_data(32'h8));
    vecs[15] = mk(1, 1, 32'h40, 1, 0, 0, 1, 32'hC, mem_data(32'hC));
    vecs[16] = mk(1, 0, 0, 1, 1, 32'h40, 0, 32'hC, mem_data(32'hC));
    vecs[17] = mk(1, 1, 32'h42, 1, 0, 0, 0, 32'hC, mem_data(32'hC));
    vecs[18] = mk(1, 0, 0, 1, 1, 32'h40, 0, 32'hC, mem_data(32'hC));
    vecs[19] = mk(1, 0, 0, 1, 0, 0, 0, 32'hC, mem_data(32'hC));
    vecs[20] = mk(1, 0, 0, 1, 1, 32'h44, 1, 32'h40, mem_data(32'h40));
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 32'h40, mem_data(32'h40));
    vecs[22] = mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'h44, mem_data(32'h44));
    vecs[23] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h44, mem_data(32'h44));
    vecs[24] = mk(1, 0, 0, 0, 0, 0, 0, 32'h44, mem_data(32'h44));
    vecs[25] = mk(1, 0, 0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC));
    vecs[26] = mk(1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, mem_data(32'hFFFF_FFFC));
    vecs[27] = mk(1, 0, 0, 0, 0, 0, 1, 32'h0, mem_data(32'h0));

    @(posedge clk);
    #1;
    for (int i = 0; i < 28; i++)
      run_cycle($sformatf("vec%0d", i), vecs[i]);

    // Redirects during a 3-cycle fetch; the later redirect in DRAIN wins.
    mem_lat = 3;
    run_cycle("lat3_req",    mk(1, 0, 0, 1, 1, 32'h4, 1, 32'h0, mem_data(32'h0)));
    run_cycle("lat3_redir1", mk(1, 1, 32'h203, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("drain_redir", mk(1, 1, 32'h103, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("drain_drop",  mk(1, 0, 0, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("reissue",     mk(1, 0, 0, 0, 1, 32'h100, 0, 32'h0, mem_data(32'h0)));
    run_cycle("wait_a",      mk(1, 0, 0, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("wait_b",      mk(1, 0, 0, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("wait_c",      mk(1, 0, 0, 0, 0, 0, 0, 32'h0, mem_data(32'h0)));
    run_cycle("redir_deliv", mk(1, 0, 0, 0, 0, 0, 1, 32'h100, mem_data(32'h100)));

    // Reset while a request is in flight.
    run_cycle("pre_rst_req", mk(1, 0, 0, 1, 1, 32'h104, 1, 32'h100, mem_data(32'h100)));
    run_cycle("rst_in_wait", mk(0, 0, 0, 1, 0, 0, 0, 32'h100, mem_data(32'h100)));
    run_cycle("post_rst",    mk(1, 0, 0, 0, 1, 32'h0, 0, 32'h0, 32'h0));
    run_cycle("post_wait_a", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    run_cycle("post_wait_b", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    run_cycle("post_wait_c", mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    run_cycle("post_deliv",  mk(1, 0, 0, 0, 0, 0, 1, 32'h0, mem_data(32'h0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
